// File: rtl/vga_sync_gen.sv
// VGA sync generator with upstream-sequence lock detection.
//
// Decodes an externally supplied (a_val, b_val) = (horizontal, vertical) count pair into sync,
// blanking and pixel-coordinate outputs. It also checks that successive samples follow the
// expected raster order and declares lock after LOCK_CNT consecutive in-order samples.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst          synchronous active-high reset
//   cen          pixel enable; a sample is taken only when cen=1
//   a_val        horizontal count from the upstream counter
//   b_val        vertical count from the upstream counter
//   hsync        horizontal sync, active low
//   vsync        vertical sync, active low
//   video_on     high inside the visible area
//   pix_x        visible column, 0 outside the visible area
//   pix_y        visible row, 0 outside the visible area
//   line_start   one-cycle pulse for a sample with a_val=0
//   frame_start  one-cycle pulse for a (0,0) sample while locked
//   frame_cnt    completed-frame counter, wraps at 255
//   locked       high while the sample sequence is locked
//   seq_err      one-cycle pulse when lock is lost
//
// Every output is registered and updates one clk after a cen=1 sample. On cen=0 cycles the
// level outputs hold and the pulse outputs return to 0.

module vga_sync_gen #(
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic [9:0] a_val,
  input  logic [9:0] b_val,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt,
  output logic       locked,
  output logic       seq_err
);

  localparam int unsigned HTot = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTot = V_VIS + V_FP + V_SYNC + V_BP;

  // Comparisons are done at 11 bits so that a total of exactly 1024 still decodes correctly.
  localparam logic [10:0] HTotW   = 11'(HTot);
  localparam logic [10:0] HLastW  = 11'(HTot - 1);
  localparam logic [10:0] HVisW   = 11'(H_VIS);
  localparam logic [10:0] HSyncLo = 11'(H_VIS + H_FP);
  localparam logic [10:0] HSyncHi = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] VTotW   = 11'(VTot);
  localparam logic [10:0] VLastW  = 11'(VTot - 1);
  localparam logic [10:0] VVisW   = 11'(V_VIS);
  localparam logic [10:0] VSyncLo = 11'(V_VIS + V_FP);
  localparam logic [10:0] VSyncHi = 11'(V_VIS + V_FP + V_SYNC);

  localparam int unsigned CntW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  // Lock is declared on the match that would take good_cnt to LOCK_CNT.
  localparam logic [CntW-1:0] LockLast = CntW'(LOCK_CNT - 1);

  typedef enum logic [0:0] {StUnlocked, StLocked} state_e;

  // Decode of the current sample.
  logic [10:0] a_ext, b_ext;
  logic        in_range;
  logic        vis;
  logic        h_act;
  logic        v_act;

  // Previous accepted sample and the position it predicts for this one.
  logic [9:0]  prev_a_q, prev_b_q;
  logic        have_prev_q;
  logic        prev_ok_q;
  logic [9:0]  exp_a, exp_b;
  logic        match;
  logic        mismatch;

  // Lock FSM.
  state_e          state_q, state_d;
  logic [CntW-1:0] good_cnt_q, good_cnt_d;
  logic            seq_err_d;
  logic            frame_start_d;

  // Output registers.
  logic       hsync_q, vsync_q, video_on_q;
  logic [9:0] pix_x_q, pix_y_q;
  logic       line_start_q, frame_start_q, seq_err_q;
  logic [7:0] frame_cnt_q;

  assign a_ext = {1'b0, a_val};
  assign b_ext = {1'b0, b_val};

  always_comb begin
    in_range = (a_ext < HTotW) && (b_ext < VTotW);
    vis      = in_range && (a_ext < HVisW) && (b_ext < VVisW);
    h_act    = in_range && (a_ext >= HSyncLo) && (a_ext < HSyncHi);
    v_act    = in_range && (b_ext >= VSyncLo) && (b_ext < VSyncHi);
  end

  // Raster successor of the previous sample.
  always_comb begin
    exp_a = '0;
    exp_b = '0;
    if ({1'b0, prev_a_q} < HLastW) begin
      exp_a = prev_a_q + 10'd1;
      exp_b = prev_b_q;
    end else if ({1'b0, prev_b_q} < VLastW) begin
      exp_a = '0;
      exp_b = prev_b_q + 10'd1;
    end
  end

  // An out-of-range predecessor has no valid successor, so whatever follows it mismatches.
  // The predicted position is always in range, so an out-of-range sample never matches.
  assign match    = have_prev_q && prev_ok_q && (a_val == exp_a) && (b_val == exp_b);
  assign mismatch = have_prev_q && !match;

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    seq_err_d  = 1'b0;
    if (cen) begin
      case (state_q)
        StUnlocked: begin
          if (match) begin
            if (good_cnt_q >= LockLast) begin
              state_d    = StLocked;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + 1'b1;
            end
          end else if (mismatch) begin
            good_cnt_d = '0;
          end
        end
        StLocked: begin
          if (mismatch) begin
            state_d    = StUnlocked;
            good_cnt_d = '0;
            seq_err_d  = 1'b1;
          end
        end
        default: begin
          state_d    = StUnlocked;
          good_cnt_d = '0;
        end
      endcase
    end
  end

  // Gated on the post-sample state so a (0,0) that also loses lock produces no frame_start.
  assign frame_start_d = in_range && (a_val == '0) && (b_val == '0) && (state_d == StLocked);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StUnlocked;
      good_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      have_prev_q <= 1'b0;
      prev_ok_q   <= 1'b0;
      prev_a_q    <= '0;
      prev_b_q    <= '0;
    end else if (cen) begin
      have_prev_q <= 1'b1;
      prev_ok_q   <= in_range;
      prev_a_q    <= a_val;
      prev_b_q    <= b_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      seq_err_q     <= 1'b0;
    end else if (cen) begin
      hsync_q       <= !h_act;
      vsync_q       <= !v_act;
      video_on_q    <= vis;
      pix_x_q       <= vis ? a_val : '0;
      pix_y_q       <= vis ? b_val : '0;
      line_start_q  <= in_range && (a_val == '0);
      frame_start_q <= frame_start_d;
      seq_err_q     <= seq_err_d;
      if (frame_start_d) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      seq_err_q     <= 1'b0;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;
  assign locked      = (state_q == StLocked);
  assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a small-raster instance checked every cycle against a linear-index
// reference model, plus a default-parameter instance probed at the standard 640x480 boundaries.

module tb_vga_sync_gen;

  localparam int HV = 16, HF = 2, HS = 3, HB = 3;
  localparam int VV = 10, VF = 2, VS = 2, VB = 2;
  localparam int LK = 4;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst, cen;
  logic [9:0] a_val, b_val, da, db;

  logic       hsync, vsync, video_on, line_start, frame_start, locked, seq_err;
  logic [9:0] pix_x, pix_y;
  logic [7:0] frame_cnt;

  logic       d_hsync, d_vsync, d_video_on, d_line_start, d_frame_start, d_locked, d_seq_err;
  logic [9:0] d_pix_x, d_pix_y;
  logic [7:0] d_frame_cnt;

  vga_sync_gen #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .LOCK_CNT(LK)
  ) dut (
    .clk(clk), .rst(rst), .cen(cen), .a_val(a_val), .b_val(b_val),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
    .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt),
    .locked(locked), .seq_err(seq_err)
  );

  vga_sync_gen dut_d (
    .clk(clk), .rst(rst), .cen(cen), .a_val(da), .b_val(db),
    .hsync(d_hsync), .vsync(d_vsync), .video_on(d_video_on), .pix_x(d_pix_x),
    .pix_y(d_pix_y), .line_start(d_line_start), .frame_start(d_frame_start),
    .frame_cnt(d_frame_cnt), .locked(d_locked), .seq_err(d_seq_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  int pos     = 0;

  // Reference model state: previous sample as a linear raster index.
  bit   m_have, m_pok, m_lock;
  int   m_pidx, m_good;
  logic e_hs, e_vs, e_von, e_ls, e_fs, e_lk, e_se;
  logic [9:0] e_px, e_py;
  logic [7:0] e_fc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int a, input int b, input bit c, input bit r);
    bit inr, mt, mm;
    int idx;
    if (r) begin
      m_have = 0; m_pok = 0; m_good = 0; m_lock = 0;
      e_hs = 1; e_vs = 1; e_von = 0; e_px = 0; e_py = 0;
      e_ls = 0; e_fs = 0; e_fc = 0; e_lk = 0; e_se = 0;
    end else if (!c) begin
      e_ls = 0; e_fs = 0; e_se = 0;
    end else begin
      inr = (a < HT) && (b < VT);
      idx = b * HT + a;
      mt  = m_have && m_pok && inr && (idx == (m_pidx + 1) % FT);
      mm  = m_have && !mt;
      e_se = 0;
      if (m_lock) begin
        if (mm) begin m_lock = 0; m_good = 0; e_se = 1; end
      end else if (mt) begin
        m_good++;
        if (m_good == LK) begin m_lock = 1; m_good = 0; end
      end else if (mm) begin
        m_good = 0;
      end
      m_have = 1; m_pok = inr; m_pidx = idx;
      e_von = inr && (a < HV) && (b < VV);
      e_hs  = !(inr && (a >= HV + HF) && (a < HV + HF + HS));
      e_vs  = !(inr && (b >= VV + VF) && (b < VV + VF + VS));
      e_px  = e_von ? 10'(a) : 10'd0;
      e_py  = e_von ? 10'(b) : 10'd0;
      e_ls  = inr && (a == 0);
      e_fs  = inr && (a == 0) && (b == 0) && m_lock;
      if (e_fs) e_fc = e_fc + 8'd1;
      e_lk  = m_lock;
    end
  endtask

  task automatic step(input int a, input int b, input bit c, input bit r);
    a_val = 10'(a); b_val = 10'(b); cen = c; rst = r;
    @(posedge clk);
    #1;
    model(a, b, c, r);
    chk("hsync", hsync, e_hs);
    chk("vsync", vsync, e_vs);
    chk("video_on", video_on, e_von);
    chk("pix_x", pix_x, e_px);
    chk("pix_y", pix_y, e_py);
    chk("line_start", line_start, e_ls);
    chk("frame_start", frame_start, e_fs);
    chk("frame_cnt", frame_cnt, e_fc);
    chk("locked", locked, e_lk);
    chk("seq_err", seq_err, e_se);
  endtask

  task automatic run_seq(input int n);
    for (int i = 0; i < n; i++) begin
      step(pos % HT, pos / HT, 1'b1, 1'b0);
      pos = (pos + 1) % FT;
    end
  endtask

  // Run in order until the sample at raster index t has just been taken.
  task automatic run_to(input int t);
    run_seq((((t - pos) % FT) + FT) % FT + 1);
  endtask

  task automatic step_d(input int a, input int b);
    bit inr;
    da = 10'(a); db = 10'(b); cen = 1'b1; rst = 1'b0;
    @(posedge clk);
    #1;
    inr = (a < 800) && (b < 525);
    chk("d_video_on", d_video_on, inr && a < 640 && b < 480);
    chk("d_hsync", d_hsync, !(inr && a >= 656 && a < 752));
    chk("d_vsync", d_vsync, !(inr && b >= 490 && b < 492));
    chk("d_pix_x", d_pix_x, (inr && a < 640 && b < 480) ? a : 0);
    chk("d_line_start", d_line_start, inr && a == 0);
  endtask

  initial begin
    a_val = 0; b_val = 0; da = 0; db = 0; cen = 0; rst = 1;

    // Reset applies regardless of cen.
    step(0, 0, 1'b0, 1'b1);
    step(5, 5, 1'b1, 1'b1);

    // In-order run from (0,0): lock on the 5th sample, frame_cnt=1 at the second (0,0).
    for (int i = 0; i < 2 * FT + 5; i++) begin
      step((i % FT) % HT, (i % FT) / HT, 1'b1, 1'b0);
      if (i == 3) chk("pre_lock", locked, 1'b0);
      if (i == 4) chk("lock_5th", locked, 1'b1);
      if (i == FT) begin
        chk("fstart_2nd", frame_start, 1'b1);
        chk("fcnt_one", frame_cnt, 8'd1);
      end
    end
    pos = 5;

    // Skip (10,5) -> (12,5) while locked, then re-lock after 4 matches.
    run_to(5 * HT + 10);
    chk("locked_before_skip", locked, 1'b1);
    step(12, 5, 1'b1, 1'b0);
    chk("skip_seq_err", seq_err, 1'b1);
    chk("skip_unlock", locked, 1'b0);
    pos = 5 * HT + 13;
    run_seq(1);
    chk("seq_err_one_cycle", seq_err, 1'b0);
    run_seq(2);
    chk("relock_not_yet", locked, 1'b0);
    run_seq(1);
    chk("relock", locked, 1'b1);

    // Out-of-range sample while both syncs are active.
    run_to((VV + VF) * HT + HV + HF);
    chk("sync_low_h", hsync, 1'b0);
    chk("sync_low_v", vsync, 1'b0);
    step(HT, 0, 1'b1, 1'b0);
    chk("oor_hsync", hsync, 1'b1);
    chk("oor_vsync", vsync, 1'b1);
    chk("oor_video", video_on, 1'b0);
    chk("oor_seq_err", seq_err, 1'b1);
    run_seq(HT);

    // Alternating cen with garbage on idle cycles.
    step(0, 0, 1'b1, 1'b1);
    pos = 0;
    for (int k = 0; k < 2 * HT; k++) begin
      run_seq(1);
      if (k == 0) chk("cen_ls_high", line_start, 1'b1);
      step($urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0, 1'b0);
      if (k == 0) chk("cen_ls_pulse", line_start, 1'b0);
      if (k == 4) chk("cen_lock_hold", locked, 1'b1);
    end

    // Randomised: mostly in-order with random cen, jumps, out-of-range and rare resets.
    for (int k = 0; k < 1500; k++) begin
      int r;
      r = $urandom_range(0, 63);
      if ($urandom_range(0, 3) == 0) begin
        step($urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0, 1'b0);
      end else if (r == 0) begin
        step(pos % HT, pos / HT, 1'b1, 1'b1);
      end else if (r < 3) begin
        pos = $urandom_range(0, FT - 1);
        run_seq(1);
      end else if (r < 5) begin
        step($urandom_range(HT, 1023), $urandom_range(0, 1023), 1'b1, 1'b0);
      end else begin
        run_seq(1);
      end
    end

    // Mid-line reset while locked with a nonzero frame count.
    step(0, 0, 1'b1, 1'b1);
    pos = 0;
    run_seq(FT + 5);
    chk("pre_rst_locked", locked, 1'b1);
    chk("pre_rst_fcnt_nz", frame_cnt != 8'd0, 1'b1);
    step(pos % HT, pos / HT, 1'b1, 1'b1);
    chk("rst_hsync", hsync, 1'b1);
    chk("rst_vsync", vsync, 1'b1);
    chk("rst_video", video_on, 1'b0);
    chk("rst_fcnt", frame_cnt, 8'd0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_pix", {pix_x, pix_y}, 20'd0);
    run_seq(4);
    chk("post_rst_no_lock", locked, 1'b0);
    run_seq(1);
    chk("post_rst_lock", locked, 1'b1);

    // Default 640x480 timing boundaries.
    step_d(0, 0);
    step_d(639, 0);
    step_d(640, 0);
    step_d(655, 0);
    step_d(656, 0);
    step_d(751, 0);
    step_d(752, 0);
    step_d(799, 0);
    step_d(700, 479);
    step_d(100, 479);
    step_d(100, 480);
    step_d(700, 489);
    step_d(700, 490);
    step_d(700, 491);
    step_d(700, 492);
    step_d(0, 524);
    step_d(800, 0);
    step_d(700, 525);
    step_d(0, 600);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
